max_pool: RTL

MAX_POOL -- requirements
Module: max_pool

---
 rtl/max_pool_pkg.sv | 29 ++
 rtl/max_pool_win.sv | 71 +++++++
 rtl/max_pool.sv | 125 ++++++++++++
 3 files changed

// File: rtl/max_pool_pkg.sv
// ============================================================================
// Module   : max_pool_pkg
// Brief    : Shared layer constants: DRAM map bases, map geometry, FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package max_pool_pkg;

    localparam logic [17:0] IN_BASE  = 18'd196608;
    localparam logic [17:0] OUT_BASE = 18'd65536;

    localparam int c_map_dim   = 10;
    localparam int c_map_depth = 16;

    // Last valid pooled coordinate along x/y and along z.
    localparam logic [2:0] c_pool_last  = 3'(c_map_dim / 2 - 1);
    localparam logic [3:0] c_depth_last = 4'(c_map_depth - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/max_pool_win.sv
// ============================================================================
// Module   : pool_win_cnt
// Brief    : Window (px,py,pz) and element (k) counters with DRAM addressing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pool_win_cnt
    import max_pool_pkg::*;
#(
    parameter int ADDR_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  clear,
    input  logic                  k_inc,
    input  logic                  win_inc,
    output logic [1:0]            k,
    output logic                  last_win,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr
);

    logic [2:0] r_px;
    logic [2:0] r_py;
    logic [3:0] r_pz;
    logic [1:0] r_k;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_px <= '0;
            r_py <= '0;
            r_pz <= '0;
            r_k  <= '0;
        end else if (clear) begin
            r_px <= '0;
            r_py <= '0;
            r_pz <= '0;
            r_k  <= '0;
        end else begin
            if (k_inc) begin
                r_k <= r_k + 2'd1;
            end
            if (win_inc) begin
                if (r_px == c_pool_last) begin
                    r_px <= '0;
                    if (r_py == c_pool_last) begin
                        r_py <= '0;
                        r_pz <= r_pz + 4'd1;
                    end else begin
                        r_py <= r_py + 3'd1;
                    end
                end else begin
                    r_px <= r_px + 3'd1;
                end
            end
        end
    end

    assign k        = r_k;
    assign last_win = (r_px == c_pool_last) && (r_py == c_pool_last) && (r_pz == c_depth_last);

    // 2*p + k bit is just the counter with the k bit appended as LSB.
    assign rd_addr = ADDR_WIDTH'(IN_BASE)
                   + ADDR_WIDTH'({r_pz, 1'b0, r_py, r_k[1], 1'b0, r_px, r_k[0]});
    assign wr_addr = ADDR_WIDTH'(OUT_BASE)
                   + ADDR_WIDTH'({r_pz, 2'b00, r_py, 2'b00, r_px});

endmodule

`default_nettype wire

// File: rtl/max_pool.sv
// ============================================================================
// Module   : max_pool
// Brief    : 2x2 stride-2 signed max-pool of a 10x10x16 DRAM map to 5x5x16.
// Revision : 1.0
// ============================================================================
`default_nettype none

module max_pool
    import max_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         enable,
    input  logic                         dram_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic [ADDR_WIDTH-1:0]        addr_in,
    output logic                         dram_en_rd,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0]        addr_out,
    output logic                         dram_en_wr,
    output logic                         done
);

    state_t                        r_state;
    state_t                        w_next_state;
    logic signed [DATA_WIDTH-1:0]  r_acc;
    logic signed [DATA_WIDTH-1:0]  w_max;
    logic                          w_clear;
    logic                          w_k_inc;
    logic                          w_win_inc;
    logic [1:0]                    w_k;
    logic                          w_last_win;
    logic [ADDR_WIDTH-1:0]         w_rd_addr;
    logic                          w_unused;

    assign w_unused = dram_valid;

    pool_win_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_win_cnt (
        .clk      (clk),
        .srstn    (srstn),
        .clear    (w_clear),
        .k_inc    (w_k_inc),
        .win_inc  (w_win_inc),
        .k        (w_k),
        .last_win (w_last_win),
        .rd_addr  (w_rd_addr),
        .wr_addr  (addr_out)
    );

    assign w_max = (data_in > r_acc) ? data_in : r_acc;

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Read data lags the address by one cycle, so k=1 sees element 0.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_acc <= '0;
        end else if (r_state == ST_RD) begin
            if (w_k == 2'd1) begin
                r_acc <= data_in;
            end else if (w_k[1]) begin
                r_acc <= w_max;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_k_inc      = 1'b0;
        w_win_inc    = 1'b0;
        addr_in      = '0;
        dram_en_rd   = 1'b0;
        dram_en_wr   = 1'b0;
        data_out     = r_acc;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_clear      = 1'b1;
                    w_next_state = ST_RD;
                end
            end
            ST_RD: begin
                addr_in    = w_rd_addr;
                dram_en_rd = 1'b1;
                w_k_inc    = 1'b1;
                if (w_k == 2'd3) begin
                    w_next_state = ST_WR;
                end
            end
            ST_WR: begin
                dram_en_wr = 1'b1;
                data_out   = w_max;
                if (w_last_win) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_win_inc    = 1'b1;
                    w_next_state = ST_RD;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
